shared_match_pe_core: RTL and testbench

- Compute engine behind the shared-match-PE mesh adapter.
- Consumes the adapter's match requests (head address, history address, tag) and compares history-buffer bytes at the two addresses, 8 bytes per step.
- Returns the match length with the unchanged tag on the response channel, which the adapter routes back over the mesh.
- Processes one request at a time; the history buffer is reached through a dual-address read port with 1-cycle latency.

---
 rtl/shared_match_pe_core_pkg.sv | 40 ++++
 rtl/shared_match_pe_core_if.sv | 41 ++++
 rtl/shared_match_pe_core_match_byte_counter.sv | 25 ++
 rtl/shared_match_pe_core.sv | 96 +++++++++
 tb/tb_shared_match_pe_core.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/shared_match_pe_core_pkg.sv
// Shared constants, state encoding and request payload for the match PE core.
// Widths mirror the adapter's parameter set so tag/length fields line up end to end.
package shared_match_pe_core_pkg;

    localparam int ADDR_WIDTH      = 16;
    localparam int NUM_JOB_PE_LOG2 = 3;
    localparam int LAZY_LEN_LOG2   = 2;
    localparam int TAG_WIDTH       = NUM_JOB_PE_LOG2 + LAZY_LEN_LOG2;
    localparam int MATCH_LEN_WIDTH = 6;
    localparam int MAX_MATCH_LEN   = 32;
    localparam int CMP_BYTES       = 8;
    localparam int DATA_WIDTH      = 8 * CMP_BYTES;
    localparam int CNT_WIDTH       = $clog2(CMP_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        COMPARE = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] head;
        logic [ADDR_WIDTH-1:0] history;
        logic [TAG_WIDTH-1:0]  tag;
    } match_req_t;

    // Accumulate in one extra bit so len+eq_cnt cannot wrap before the cap is applied.
    function automatic logic [MATCH_LEN_WIDTH-1:0] sat_len(
        input logic [MATCH_LEN_WIDTH-1:0] len,
        input logic [CNT_WIDTH-1:0]       eq_cnt
    );
        logic [MATCH_LEN_WIDTH:0] sum;
        sum = {1'b0, len} + (MATCH_LEN_WIDTH+1)'(eq_cnt);
        if (sum >= (MATCH_LEN_WIDTH+1)'(MAX_MATCH_LEN))
            return MATCH_LEN_WIDTH'(MAX_MATCH_LEN);
        return sum[MATCH_LEN_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/shared_match_pe_core_if.sv
// Request/response channels plus the dual-address history read port.
// master = adapter/memory side, slave = the core.
interface shared_match_pe_core_if;
    import shared_match_pe_core_pkg::*;

    logic                       match_req_valid;
    logic                       match_req_ready;
    logic [ADDR_WIDTH-1:0]      match_req_head_addr;
    logic [ADDR_WIDTH-1:0]      match_req_history_addr;
    logic [TAG_WIDTH-1:0]       match_req_tag;

    logic                       match_resp_valid;
    logic                       match_resp_ready;
    logic [TAG_WIDTH-1:0]       match_resp_tag;
    logic [MATCH_LEN_WIDTH-1:0] match_resp_match_len;

    logic                       mem_rd_en;
    logic [ADDR_WIDTH-1:0]      mem_rd_addr_a;
    logic [ADDR_WIDTH-1:0]      mem_rd_addr_b;
    logic [DATA_WIDTH-1:0]      mem_rd_data_a;
    logic [DATA_WIDTH-1:0]      mem_rd_data_b;

    modport master (
        output match_req_valid, match_req_head_addr, match_req_history_addr, match_req_tag,
        input  match_req_ready,
        input  match_resp_valid, match_resp_tag, match_resp_match_len,
        output match_resp_ready,
        input  mem_rd_en, mem_rd_addr_a, mem_rd_addr_b,
        output mem_rd_data_a, mem_rd_data_b
    );

    modport slave (
        input  match_req_valid, match_req_head_addr, match_req_history_addr, match_req_tag,
        output match_req_ready,
        output match_resp_valid, match_resp_tag, match_resp_match_len,
        input  match_resp_ready,
        output mem_rd_en, mem_rd_addr_a, mem_rd_addr_b,
        input  mem_rd_data_a, mem_rd_data_b
    );

endinterface

// File: rtl/shared_match_pe_core_match_byte_counter.sv
// Leading-equal byte count of two words, byte 0 first; result 0..CMP_BYTES.
module match_byte_counter
    import shared_match_pe_core_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [CNT_WIDTH-1:0]  eq_cnt
);

    logic [CMP_BYTES-1:0] eq_mask;

    for (genvar i = 0; i < CMP_BYTES; i++) begin : g_byte
        assign eq_mask[i] = (data_a[8*i +: 8] == data_b[8*i +: 8]);
    end

    // Scan downward so the lowest mismatching byte is the one that sticks.
    always_comb begin
        eq_cnt = CNT_WIDTH'(CMP_BYTES);
        for (int i = CMP_BYTES - 1; i >= 0; i--) begin
            if (!eq_mask[i])
                eq_cnt = CNT_WIDTH'(i);
        end
    end

endmodule

// File: rtl/shared_match_pe_core.sv
// Match-length engine: one request at a time, 8 bytes compared per FETCH/COMPARE pair.
// All handshake and memory outputs are registered straight off the FSM.
module shared_match_pe_core
    import shared_match_pe_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    shared_match_pe_core_if.slave bus
);

    state_e                     state;
    match_req_t                 req_q;
    logic [MATCH_LEN_WIDTH-1:0] len_q;
    logic                       ready_q;
    logic                       resp_valid_q;
    logic                       rd_en_q;

    logic [CNT_WIDTH-1:0]       eq_cnt;
    logic [MATCH_LEN_WIDTH-1:0] len_next;
    logic                       step_more;

    match_byte_counter u_cnt (
        .data_a (bus.mem_rd_data_a),
        .data_b (bus.mem_rd_data_b),
        .eq_cnt (eq_cnt)
    );

    assign len_next  = sat_len(len_q, eq_cnt);
    assign step_more = (eq_cnt == CNT_WIDTH'(CMP_BYTES)) &&
                       (len_next < MATCH_LEN_WIDTH'(MAX_MATCH_LEN));

    // ready_q comes out of reset set, so it must be masked while rst is still high.
    assign bus.match_req_ready      = ready_q & ~rst;
    assign bus.match_resp_valid     = resp_valid_q;
    assign bus.match_resp_tag       = req_q.tag;
    assign bus.match_resp_match_len = len_q;
    assign bus.mem_rd_en            = rd_en_q;
    assign bus.mem_rd_addr_a        = req_q.head;
    assign bus.mem_rd_addr_b        = req_q.history;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_q        <= '0;
            len_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.match_req_valid && ready_q) begin
                        req_q.head    <= bus.match_req_head_addr;
                        req_q.history <= bus.match_req_history_addr;
                        req_q.tag     <= bus.match_req_tag;
                        len_q         <= '0;
                        ready_q       <= 1'b0;
                        // Zero distance would trivially self-match; report 0 without reading.
                        if (bus.match_req_head_addr != bus.match_req_history_addr) begin
                            state   <= FETCH;
                            rd_en_q <= 1'b1;
                        end else begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    rd_en_q <= 1'b0;
                    state   <= COMPARE;
                end
                COMPARE: begin
                    len_q <= len_next;
                    if (step_more) begin
                        req_q.head    <= req_q.head    + ADDR_WIDTH'(CMP_BYTES);
                        req_q.history <= req_q.history + ADDR_WIDTH'(CMP_BYTES);
                        rd_en_q       <= 1'b1;
                        state         <= FETCH;
                    end else begin
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.match_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_match_pe_core.sv
// Directed bench for shared_match_pe_core with a byte-array history memory model.
module tb_shared_match_pe_core;
    import shared_match_pe_core_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shared_match_pe_core_if bus ();

    shared_match_pe_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0]  mem [0:65535];
    int          rd_cnt;
    logic [15:0] rd_a [$];
    logic [15:0] rd_b [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [15:0] addr);
        logic [DATA_WIDTH-1:0] w;
        logic [15:0]           ad;
        for (int i = 0; i < CMP_BYTES; i++) begin
            ad = addr + 16'(i);
            w[8*i +: 8] = mem[ad];
        end
        return w;
    endfunction

    // 1-cycle-latency read port plus a log of every read strobe
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data_a <= rd_word(bus.mem_rd_addr_a);
            bus.mem_rd_data_b <= rd_word(bus.mem_rd_addr_b);
            rd_cnt <= rd_cnt + 1;
            rd_a.push_back(bus.mem_rd_addr_a);
            rd_b.push_back(bus.mem_rd_addr_b);
        end
    end

    // First n_eq bytes at hist match those at head; byte n_eq onward differs.
    task automatic fill(input logic [15:0] head, input logic [15:0] hist, input int n_eq);
        logic [15:0] ah, ab;
        logic [7:0]  v;
        for (int i = 0; i < 64; i++) begin
            ah = head + 16'(i);
            ab = hist + 16'(i);
            v  = 8'(i * 7 + 3);
            mem[ah] = v;
            mem[ab] = (i < n_eq) ? v : ~v;
        end
        rd_cnt = 0;
        rd_a.delete();
        rd_b.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; lat = cycles from accept to first resp_valid, -1 on timeout.
    task automatic send(input logic [15:0] head, input logic [15:0] hist,
                        input logic [4:0] tag, output int lat);
        bus.match_req_valid        = 1'b1;
        bus.match_req_head_addr    = head;
        bus.match_req_history_addr = hist;
        bus.match_req_tag          = tag;
        lat = -1;
        for (int k = 0; k < 20 && !bus.match_req_ready; k++) tick();
        if (!bus.match_req_ready) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        bus.match_req_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.match_resp_valid) begin
                lat = k + 1;
                break;
            end
            tick();
        end
        if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    int lat;

    initial begin
        rst                        = 1'b1;
        bus.match_req_valid        = 1'b0;
        bus.match_req_head_addr    = '0;
        bus.match_req_history_addr = '0;
        bus.match_req_tag          = '0;
        bus.match_resp_ready       = 1'b1;
        bus.mem_rd_data_a          = '0;
        bus.mem_rd_data_b          = '0;
        rd_cnt                     = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        tick(); tick(); tick();
        chk("rst_ready",   32'(bus.match_req_ready),      32'd0);
        chk("rst_rvalid",  32'(bus.match_resp_valid),     32'd0);
        chk("rst_rden",    32'(bus.mem_rd_en),            32'd0);
        chk("rst_len",     32'(bus.match_resp_match_len), 32'd0);
        chk("rst_tag",     32'(bus.match_resp_tag),       32'd0);
        chk("rst_addr_a",  32'(bus.mem_rd_addr_a),        32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus.match_req_ready), 32'd1);

        // mismatch at byte 3
        fill(16'h0100, 16'h0040, 3);
        send(16'h0100, 16'h0040, 5'h13, lat);
        chk("b3_lat",   32'(lat), 32'd3);
        chk("b3_len",   32'(bus.match_resp_match_len), 32'd3);
        chk("b3_tag",   32'(bus.match_resp_tag), 32'h13);
        chk("b3_reads", 32'(rd_cnt), 32'd1);
        chk("b3_addr_a", 32'(rd_a[0]), 32'h0100);
        chk("b3_addr_b", 32'(rd_b[0]), 32'h0040);
        chk("b3_ready_busy", 32'(bus.match_req_ready), 32'd0);
        tick();
        chk("b3_rvalid_drop", 32'(bus.match_resp_valid), 32'd0);
        chk("b3_ready_back",  32'(bus.match_req_ready),  32'd1);

        // 20-byte match: three reads
        fill(16'h0100, 16'h0040, 20);
        send(16'h0100, 16'h0040, 5'h07, lat);
        chk("long_lat",   32'(lat), 32'd7);
        chk("long_len",   32'(bus.match_resp_match_len), 32'd20);
        chk("long_tag",   32'(bus.match_resp_tag), 32'h07);
        chk("long_reads", 32'(rd_cnt), 32'd3);
        chk("long_a1",    32'(rd_a[1]), 32'h0108);
        chk("long_a2",    32'(rd_a[2]), 32'h0110);
        chk("long_b2",    32'(rd_b[2]), 32'h0050);
        tick();

        // saturation at 32
        fill(16'h0100, 16'h0040, 64);
        send(16'h0100, 16'h0040, 5'h1F, lat);
        chk("sat_lat",   32'(lat), 32'd9);
        chk("sat_len",   32'(bus.match_resp_match_len), 32'd32);
        chk("sat_tag",   32'(bus.match_resp_tag), 32'h1F);
        tick(); tick(); tick();
        chk("sat_reads", 32'(rd_cnt), 32'd4);
        chk("sat_a3",    32'(rd_a[3]), 32'h0118);

        // zero distance
        fill(16'h0200, 16'h0300, 64);
        send(16'h0200, 16'h0200, 5'h0A, lat);
        chk("zero_lat",   32'(lat), 32'd1);
        chk("zero_len",   32'(bus.match_resp_match_len), 32'd0);
        chk("zero_tag",   32'(bus.match_resp_tag), 32'h0A);
        chk("zero_reads", 32'(rd_cnt), 32'd0);
        tick();

        // address wrap with response backpressure
        fill(16'hFFFC, 16'h7FFC, 16);
        bus.match_resp_ready = 1'b0;
        send(16'hFFFC, 16'h7FFC, 5'h15, lat);
        chk("wrap_lat",   32'(lat), 32'd7);
        chk("wrap_a1",    32'(rd_a[1]), 32'h0004);
        chk("wrap_b1",    32'(rd_b[1]), 32'h8004);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_rvalid", 32'(bus.match_resp_valid),     32'd1);
            chk("bp_len",    32'(bus.match_resp_match_len), 32'd16);
            chk("bp_tag",    32'(bus.match_resp_tag),       32'h15);
            chk("bp_ready",  32'(bus.match_req_ready),      32'd0);
        end
        chk("bp_reads", 32'(rd_cnt), 32'd3);
        bus.match_resp_ready = 1'b1;
        tick();
        chk("bp_release_rvalid", 32'(bus.match_resp_valid), 32'd0);
        chk("bp_release_ready",  32'(bus.match_req_ready),  32'd1);

        // reset while in COMPARE
        fill(16'h0100, 16'h0040, 20);
        bus.match_req_valid        = 1'b1;
        bus.match_req_head_addr    = 16'h0100;
        bus.match_req_history_addr = 16'h0040;
        bus.match_req_tag          = 5'h09;
        tick();
        bus.match_req_valid = 1'b0;
        chk("mid_fetch_rden", 32'(bus.mem_rd_en), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_ready",  32'(bus.match_req_ready),  32'd0);
        chk("mid_rst_rvalid", 32'(bus.match_resp_valid), 32'd0);
        chk("mid_rst_rden",   32'(bus.mem_rd_en),        32'd0);
        rst = 1'b0;
        tick();
        chk("mid_after_ready", 32'(bus.match_req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("mid_no_rvalid", 32'(bus.match_resp_valid), 32'd0);
            tick();
        end

        fill(16'h0100, 16'h0040, 3);
        send(16'h0100, 16'h0040, 5'h11, lat);
        chk("post_lat", 32'(lat), 32'd3);
        chk("post_len", 32'(bus.match_resp_match_len), 32'd3);
        chk("post_tag", 32'(bus.match_resp_tag), 32'h11);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
